// File: rtl/polar_pkg.sv
// Shared constants and types for the SCAN decoder channel-LLR front end.
// Geometry is fixed by the 1024/128 code; all sizes derive from Q/P/N/W.
package polar_pkg;
   localparam int Q = 6;
   localparam int P = 128;
   localparam int N = 1024;
   localparam int W = 16;

   localparam int WORDS          = N / P;
   localparam int HALF           = N / (2 * P);
   localparam int BEATS          = N / W;
   localparam int BEATS_PER_WORD = P / W;

   localparam int BEAT_BITS = W * Q;
   localparam int WORD_BITS = P * Q;
   localparam int CNT_W     = $clog2(BEATS);
   localparam int WORD_W    = $clog2(WORDS);
   localparam int SLOT_W    = $clog2(BEATS_PER_WORD);
   localparam int HALF_W    = $clog2(HALF);
   localparam int OFS_W     = $clog2(WORD_BITS);

   typedef enum logic [0:0] {
      LOAD = 1'b0,
      FULL = 1'b1
   } load_state_t;
endpackage

// File: rtl/llr_beat_packer.sv
// Beat counter for the channel-LLR loader: turns accepted beats into
// word/slot write addresses and flags the final beat of a frame.
module llr_beat_packer
   import polar_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              accept,
   output logic              wr_en,
   output logic [WORD_W-1:0] wr_word,
   output logic [SLOT_W-1:0] wr_slot,
   output logic              last_beat
);

   logic [CNT_W-1:0] beat_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         beat_cnt <= '0;
      end else if (accept) begin
         beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
      end
   end

   // Upper counter bits select the word, lower bits the W-lane slot in it.
   assign wr_en     = accept;
   assign wr_word   = beat_cnt[CNT_W-1 -: WORD_W];
   assign wr_slot   = beat_cnt[SLOT_W-1:0];
   assign last_beat = (beat_cnt == CNT_W'(BEATS - 1));

endmodule

// File: rtl/chan_llr_loader.sv
// Layer-10 channel-LLR store: packs one streamed frame into P-lane words,
// then serves registered left/right half reads until the decoder releases it.
module chan_llr_loader
   import polar_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [BEAT_BITS-1:0] s_data,
   output logic                 frame_rdy,
   input  logic                 frame_done,
   input  logic                 r_en,
   input  logic [HALF_W-1:0]    cntb,
   output logic [WORD_BITS-1:0] a_out_left,
   output logic [WORD_BITS-1:0] a_out_right
);

   load_state_t         state;
   load_state_t         state_nxt;
   logic                accept;
   logic                wr_en;
   logic [WORD_W-1:0]   wr_word;
   logic [SLOT_W-1:0]   wr_slot;
   logic                last_beat;
   logic [OFS_W-1:0]    slot_ofs;
   logic [WORD_W-1:0]   left_idx;
   logic [WORD_W-1:0]   right_idx;
   logic                rd_hit;
   logic [WORD_BITS-1:0] mem [WORDS];

   assign s_ready   = (state == LOAD);
   assign frame_rdy = (state == FULL);
   assign accept    = s_valid && s_ready;

   llr_beat_packer u_packer (
      .clk       (clk),
      .rst       (rst),
      .accept    (accept),
      .wr_en     (wr_en),
      .wr_word   (wr_word),
      .wr_slot   (wr_slot),
      .last_beat (last_beat)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         LOAD:    if (accept && last_beat) state_nxt = FULL;
         FULL:    if (frame_done) state_nxt = LOAD;
         default: state_nxt = LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= LOAD;
      end else begin
         state <= state_nxt;
      end
   end

   // Storage carries no reset; a partial frame is simply overwritten.
   assign slot_ofs = OFS_W'(wr_slot) * OFS_W'(BEAT_BITS);

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_word][slot_ofs +: BEAT_BITS] <= s_data;
      end
   end

   assign left_idx  = WORD_W'(cntb);
   assign right_idx = WORD_W'(cntb) + WORD_W'(HALF);
   assign rd_hit    = r_en && (state == FULL);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_out_left  <= '0;
         a_out_right <= '0;
      end else begin
         a_out_left  <= rd_hit ? mem[left_idx]  : '0;
         a_out_right <= rd_hit ? mem[right_idx] : '0;
      end
   end

endmodule

// File: tb/tb_chan_llr_loader.sv
// Directed bench for chan_llr_loader: frame loads, half reads, release
// handshake and asynchronous reset recovery.
module tb_chan_llr_loader;
   import polar_pkg::*;

   logic                 clk;
   logic                 rst;
   logic                 s_valid;
   logic                 s_ready;
   logic [BEAT_BITS-1:0] s_data;
   logic                 frame_rdy;
   logic                 frame_done;
   logic                 r_en;
   logic [HALF_W-1:0]    cntb;
   logic [WORD_BITS-1:0] a_out_left;
   logic [WORD_BITS-1:0] a_out_right;

   int checks = 0;
   int errors = 0;

   chan_llr_loader dut (
      .clk         (clk),
      .rst         (rst),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_data      (s_data),
      .frame_rdy   (frame_rdy),
      .frame_done  (frame_done),
      .r_en        (r_en),
      .cntb        (cntb),
      .a_out_left  (a_out_left),
      .a_out_right (a_out_right)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [WORD_BITS-1:0] got,
                      input logic [WORD_BITS-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // mode 0: k mod 64; mode 1: same XOR 0x2A; mode 2: word-distinct pattern
   function automatic logic [Q-1:0] pat(input int mode, input int k);
      int v;
      case (mode)
         0:       v = k % 64;
         1:       v = (k % 64) ^ 'h2A;
         default: v = (k * 7 + k / 128) % 64;
      endcase
      return Q'(v);
   endfunction

   function automatic logic [BEAT_BITS-1:0] beat_data(input int mode, input int b);
      logic [BEAT_BITS-1:0] d;
      for (int j = 0; j < W; j++) d[j*Q +: Q] = pat(mode, W * b + j);
      return d;
   endfunction

   function automatic logic [WORD_BITS-1:0] exp_word(input int mode, input int w);
      logic [WORD_BITS-1:0] d;
      for (int i = 0; i < P; i++) d[i*Q +: Q] = pat(mode, P * w + i);
      return d;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_beats(input int mode, input int nbeats, input bit gap);
      for (int b = 0; b < nbeats; b++) begin
         if (b == BEATS - 1) chk("rdy_before_last", {767'b0, frame_rdy}, '0);
         s_valid = 1'b1;
         s_data  = beat_data(mode, b);
         tick();
         if (gap) begin
            s_valid = 1'b0;
            s_data  = '1;
            tick();
         end
      end
      s_valid = 1'b0;
   endtask

   task automatic do_read(input string tag, input int mode, input int c);
      r_en = 1'b1;
      cntb = HALF_W'(c);
      tick();
      r_en = 1'b0;
      chk({tag, "_left"},  a_out_left,  exp_word(mode, c));
      chk({tag, "_right"}, a_out_right, exp_word(mode, c + HALF));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b0; s_valid = 1'b0; s_data = '0;
      frame_done = 1'b0; r_en = 1'b0; cntb = '0;
      #1;
      chk("rst_s_ready",   {767'b0, s_ready},   768'd1);
      chk("rst_frame_rdy", {767'b0, frame_rdy}, '0);
      chk("rst_left",      a_out_left,          '0);
      chk("rst_right",     a_out_right,         '0);
      tick();
      rst = 1'b1;
      tick();

      // continuous frame
      send_beats(0, BEATS, 1'b0);
      chk("f0_s_ready",   {767'b0, s_ready},   '0);
      chk("f0_frame_rdy", {767'b0, frame_rdy}, 768'd1);
      do_read("f0_c2", 0, 2);

      // FULL ignores input beats
      s_valid = 1'b1;
      s_data  = '1;
      for (int i = 0; i < 10; i++) tick();
      s_valid = 1'b0;
      chk("full_s_ready", {767'b0, s_ready}, '0);
      do_read("full_c0", 0, 0);

      r_en = 1'b0;
      tick();
      chk("ren0_left",  a_out_left,  '0);
      chk("ren0_right", a_out_right, '0);

      // read and release in the same cycle
      r_en = 1'b1; cntb = 2'd3; frame_done = 1'b1;
      tick();
      frame_done = 1'b0;
      chk("rel_left",      a_out_left,          exp_word(0, 3));
      chk("rel_right",     a_out_right,         exp_word(0, 7));
      chk("rel_s_ready",   {767'b0, s_ready},   768'd1);
      chk("rel_frame_rdy", {767'b0, frame_rdy}, '0);
      cntb = 2'd0;
      tick();
      r_en = 1'b0;
      chk("load_rd_left",  a_out_left,  '0);
      chk("load_rd_right", a_out_right, '0);

      // gapped frame with XOR pattern
      send_beats(1, BEATS, 1'b1);
      chk("f1_frame_rdy", {767'b0, frame_rdy}, 768'd1);
      for (int c = 0; c < HALF; c++) do_read($sformatf("f1_c%0d", c), 1, c);

      // async reset while read outputs are live
      r_en = 1'b1; cntb = 2'd1;
      tick();
      chk("pre_rst_left", a_out_left, exp_word(1, 1));
      #2 rst = 1'b0;
      #1;
      chk("arst_left",      a_out_left,          '0);
      chk("arst_right",     a_out_right,         '0);
      chk("arst_s_ready",   {767'b0, s_ready},   768'd1);
      chk("arst_frame_rdy", {767'b0, frame_rdy}, '0);
      r_en = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      tick();

      // partial frame then reset; a fresh frame must restart at beat 0
      send_beats(1, 31, 1'b0);
      chk("part_frame_rdy", {767'b0, frame_rdy}, '0);
      #2 rst = 1'b0;
      #1;
      chk("part_rst_left", a_out_left, '0);
      @(negedge clk);
      rst = 1'b1;
      tick();
      send_beats(2, BEATS, 1'b0);
      chk("f2_frame_rdy", {767'b0, frame_rdy}, 768'd1);
      for (int c = 0; c < HALF; c++) do_read($sformatf("f2_c%0d", c), 2, c);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
